// File: rtl/fp_wrapper_pkg.sv
// Shared definitions for the FP multiplier wrappers: product width, output
// wrapper state encoding and beat-count helpers.
package fp_wrapper_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    RELEASE
  } ow_state_e;

  function automatic int beat_count(input int fp_w, input int out_w);
    return fp_w / out_w;
  endfunction

  // Counter is at least one bit wide even for a single-beat product
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/out_wrapper_if.sv
// Narrow output bus: one OUT_W beat per four-phase outReady/outAccept cycle.
interface out_wrapper_if #(
  parameter int OUT_W = 16
);
  logic             outReady;
  logic [OUT_W-1:0] outData;
  logic             outLast;
  logic             outAccept;

  modport master (output outReady, outData, outLast, input outAccept);
  modport slave  (input outReady, outData, outLast, output outAccept);
endinterface

// File: rtl/out_wrapper_cu.sv
// Output wrapper controller: Moore FSM plus beat counter, issues load/shift
// strobes to the datapath and decodes the handshake outputs.
module out_wrapper_cu import fp_wrapper_pkg::*; #(
  parameter int BEATS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic fpDone,
  input  logic outAccept,
  output logic load,
  output logic shift,
  output logic outReady,
  output logic outLast,
  output logic busy
);

  localparam int              CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  ow_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fpDone) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (outAccept) state_d = RELEASE;
      end
      RELEASE: begin
        // Advance only once the consumer has dropped its acknowledge
        if (!outAccept) begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
          end else begin
            shift   = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = PRESENT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign outReady = (state_q == PRESENT);
  assign busy     = (state_q != IDLE);
  assign outLast  = busy && (cnt_q == LAST);

endmodule

// File: rtl/out_wrapper.sv
// Output-side wrapper of the FP multiplier: captures the product on fpDone and
// streams it LSB beat first over the four-phase output bus.
module out_wrapper import fp_wrapper_pkg::*; #(
  parameter int FP_W  = fp_wrapper_pkg::FP_W,
  parameter int OUT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fpDone,
  input  logic [FP_W-1:0]   fpResult,
  out_wrapper_if.master     bus,
  output logic              busy,
  output logic              overrun
);

  localparam int BEATS = beat_count(FP_W, OUT_W);

  if ((FP_W % OUT_W) != 0 || !(OUT_W == 8 || OUT_W == 16 || OUT_W == 32)) begin : g_bad_out_w
    $error("out_wrapper: OUT_W must be 8, 16 or 32 and divide FP_W");
  end

  logic            load, shift;
  logic [FP_W-1:0] shreg_q, shreg_d;
  logic            ovr_q, ovr_d;

  out_wrapper_cu #(.BEATS(BEATS)) u_cu (
    .clk       (clk),
    .rst       (rst),
    .fpDone    (fpDone),
    .outAccept (bus.outAccept),
    .load      (load),
    .shift     (shift),
    .outReady  (bus.outReady),
    .outLast   (bus.outLast),
    .busy      (busy)
  );

  // A product arriving while one is in flight is dropped and flagged
  always_comb begin
    shreg_d = shreg_q;
    if (load)       shreg_d = fpResult;
    else if (shift) shreg_d = shreg_q >> OUT_W;
    ovr_d = ovr_q | (fpDone & busy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.outData = shreg_q[OUT_W-1:0];
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_out_wrapper.sv
// Self-checking bench for out_wrapper at OUT_W = 16, 8 and 32; expected beats
// are sliced arithmetically from each product by a transaction-level consumer.
module tb_out_wrapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  fpd;
  logic [31:0] fpr;
  logic [2:0]  acc;
  logic [2:0]  rdy, lst, bsy, ovr;
  logic [31:0] dat [3];
  logic [2:0]  ovr_m;

  int n_chk  = 0;
  int n_pass = 0;

  out_wrapper_if #(.OUT_W(16)) if16 ();
  out_wrapper_if #(.OUT_W(8))  if8  ();
  out_wrapper_if #(.OUT_W(32)) if32 ();

  assign if16.outAccept = acc[0];
  assign if8.outAccept  = acc[1];
  assign if32.outAccept = acc[2];
  assign rdy[0] = if16.outReady;  assign lst[0] = if16.outLast;  assign dat[0] = 32'(if16.outData);
  assign rdy[1] = if8.outReady;   assign lst[1] = if8.outLast;   assign dat[1] = 32'(if8.outData);
  assign rdy[2] = if32.outReady;  assign lst[2] = if32.outLast;  assign dat[2] = if32.outData;

  out_wrapper #(.FP_W(32), .OUT_W(16)) u16 (
    .clk(clk), .rst(rst), .fpDone(fpd[0]), .fpResult(fpr), .bus(if16),
    .busy(bsy[0]), .overrun(ovr[0]));
  out_wrapper #(.FP_W(32), .OUT_W(8)) u8 (
    .clk(clk), .rst(rst), .fpDone(fpd[1]), .fpResult(fpr), .bus(if8),
    .busy(bsy[1]), .overrun(ovr[1]));
  out_wrapper #(.FP_W(32), .OUT_W(32)) u32 (
    .clk(clk), .rst(rst), .fpDone(fpd[2]), .fpResult(fpr), .bus(if32),
    .busy(bsy[2]), .overrun(ovr[2]));

  function automatic int wid(input int d);
    return (d == 0) ? 16 : (d == 1) ? 8 : 32;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Pulse fpDone for one cycle into an idle wrapper; outReady must follow at once
  task automatic send(input int d, input logic [31:0] p);
    fpd[d] = 1'b1;
    fpr    = p;
    step();
    fpd[d] = 1'b0;
    chk("latency_ready", 32'(rdy[d]), 32'd1);
  endtask

  // Consumer: checks every beat against the product, acking after dly cycles
  // and releasing after hold cycles; optionally injects a colliding fpDone.
  task automatic consume(input int d, input logic [31:0] prod, input int dly,
                         input int hold, input bit inj);
    int          w, nb, t;
    logic [63:0] mask, expv;
    w    = wid(d);
    nb   = 32 / w;
    mask = (64'd1 << w) - 64'd1;
    for (int b = 0; b < nb; b++) begin
      t = 0;
      while (rdy[d] !== 1'b1 && t < 40) begin step(); t++; end
      chk("beat_ready", 32'(rdy[d]), 32'd1);
      expv = ({32'd0, prod} >> (b * w)) & mask;
      chk("beat_data", dat[d], expv[31:0]);
      chk("beat_last", 32'(lst[d]), 32'(b == nb - 1));
      chk("beat_busy", 32'(bsy[d]), 32'd1);
      if (inj && b == 0) begin
        fpd[d] = 1'b1;
        fpr    = $urandom;
        step();
        fpd[d]   = 1'b0;
        fpr      = prod;
        ovr_m[d] = 1'b1;
        chk("overrun_set", 32'(ovr[d]), 32'd1);
        chk("overrun_data", dat[d], expv[31:0]);
      end
      for (int i = 0; i < dly; i++) begin
        step();
        chk("wait_ready", 32'(rdy[d]), 32'd1);
        chk("wait_data", dat[d], expv[31:0]);
      end
      acc[d] = 1'b1;
      step();
      chk("rel_ready", 32'(rdy[d]), 32'd0);
      chk("rel_data", dat[d], expv[31:0]);
      chk("rel_last", 32'(lst[d]), 32'(b == nb - 1));
      for (int i = 0; i < hold; i++) begin
        step();
        chk("rel_hold_ready", 32'(rdy[d]), 32'd0);
        chk("rel_hold_data", dat[d], expv[31:0]);
      end
      acc[d] = 1'b0;
      step();
    end
    chk("end_busy", 32'(bsy[d]), 32'd0);
    chk("end_overrun", 32'(ovr[d]), 32'(ovr_m[d]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p;
    rst   = 1'b1;
    fpd   = '0;
    fpr   = '0;
    acc   = '0;
    ovr_m = '0;
    step(); step();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 32'(rdy[d]), 32'd0);
      chk("rst_data", dat[d], 32'd0);
      chk("rst_last", 32'(lst[d]), 32'd0);
      chk("rst_busy", 32'(bsy[d]), 32'd0);
      chk("rst_overrun", 32'(ovr[d]), 32'd0);
    end

    // outAccept in IDLE has no effect
    acc[0] = 1'b1; step(); step();
    chk("idle_acc_ready", 32'(rdy[0]), 32'd0);
    chk("idle_acc_busy", 32'(bsy[0]), 32'd0);
    acc[0] = 1'b0; step();

    // Basic transfer, then slow consumer
    send(0, 32'h3FC0_0000);
    consume(0, 32'h3FC0_0000, 1, 1, 1'b0);
    send(0, 32'hCAFE_F00D);
    consume(0, 32'hCAFE_F00D, 10, 5, 1'b0);

    // Overrun during beat 1
    send(0, 32'h1234_5678);
    consume(0, 32'h1234_5678, 0, 0, 1'b1);

    // Reset while in RELEASE of beat 1
    send(0, 32'h89AB_CDEF);
    acc[0] = 1'b1; step();
    chk("pre_rst_ready", 32'(rdy[0]), 32'd0);
    rst = 1'b1; acc[0] = 1'b0; step();
    rst = 1'b0;
    ovr_m = '0;
    chk("mid_rst_ready", 32'(rdy[0]), 32'd0);
    chk("mid_rst_busy", 32'(bsy[0]), 32'd0);
    chk("mid_rst_overrun", 32'(ovr[0]), 32'd0);
    step();
    chk("post_rst_ready", 32'(rdy[0]), 32'd0);
    send(0, 32'h0000_0001);
    consume(0, 32'h0000_0001, 0, 0, 1'b0);

    // Width sweep
    send(1, 32'hA1B2_C3D4);
    consume(1, 32'hA1B2_C3D4, 1, 1, 1'b0);
    send(2, 32'hA1B2_C3D4);
    consume(2, 32'hA1B2_C3D4, 1, 1, 1'b0);

    // Randomized products, widths, consumer timing and collisions
    for (int k = 0; k < 12; k++) begin
      int d;
      d = int'($urandom_range(0, 2));
      p = $urandom;
      send(d, p);
      consume(d, p, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0));
      repeat (int'($urandom_range(0, 2))) step();
    end

    // Back-to-back with fpDone held high
    fpd[0] = 1'b1;
    fpr    = 32'h1111_2222;
    step();
    chk("b2b_first_ready", 32'(rdy[0]), 32'd1);
    fpr      = 32'h3333_4444;
    ovr_m[0] = 1'b1;
    consume(0, 32'h1111_2222, 0, 0, 1'b0);
    step();
    chk("b2b_capture_ready", 32'(rdy[0]), 32'd1);
    consume(0, 32'h3333_4444, 1, 0, 1'b0);
    fpd[0] = 1'b0;
    step();
    chk("b2b_final_busy", 32'(bsy[0]), 32'd0);
    chk("b2b_overrun", 32'(ovr[0]), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/out_wrapper.md
Name: out_wrapper

Overview:
- Output-side wrapper of the 32-bit floating-point multiplier.
- Captures the finished product when the core signals completion.
- Serialises the product onto a narrow output bus as OUT_W-bit beats, least-significant beat first.
- Each beat uses a four-phase outReady/outAccept handshake with the downstream consumer, mirroring the input-side loading of A and B.

Parameters:
- FP_W, 32, product width in bits.
- OUT_W, 16, output bus width. Must divide FP_W; legal values 8, 16, 32.
- BEATS, FP_W/OUT_W, number of beats per product (derived, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- fpDone  input  1  core has a valid product this cycle (level or pulse)
- fpResult  input  FP_W  product from the multiplier; valid while fpDone=1
- outAccept  input  1  consumer acknowledge (four-phase)
- outReady  output  1  current beat on outData is valid
- outData  output  OUT_W  current beat
- outLast  output  1  current beat is the final beat of the product
- busy  output  1  wrapper holds an unsent or partially sent product
- overrun  output  1  sticky: fpDone arrived while busy

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE, beat counter=0, shift register=0.
  - outReady=0, outData=0, outLast=0, busy=0, overrun=0.
  - Reset mid-transfer abandons the product; no further beats are presented.
- State machine is Moore: outReady, outLast and busy are decoded from registered state and counter only.
- IDLE:
  - busy=0.
  - If fpDone=1: capture fpResult into the shift register, clear the beat counter, go to PRESENT.
  - outAccept is ignored in IDLE.
- PRESENT:
  - outReady=1, busy=1.
  - outData = shift register [OUT_W-1:0].
  - outLast=1 iff beat counter == BEATS-1.
  - If outAccept=1: go to RELEASE. Otherwise hold, with no timeout.
  - If outAccept is already high on entry, it counts as an acknowledge; transition on the next edge.
- RELEASE:
  - outReady=0, busy=1.
  - outData and outLast hold their PRESENT values.
  - If outAccept=0 and counter == BEATS-1: go to IDLE.
  - If outAccept=0 and counter < BEATS-1: shift register >>= OUT_W, counter += 1, go to PRESENT.
  - If outAccept=1: stay in RELEASE.
- Latency:
  - fpDone sampled at edge n → outReady=1 from edge n+1.
  - Minimum 2 cycles per beat, so minimum 2·BEATS cycles per product, plus 1 cycle back in IDLE.
- Overrun:
  - fpDone=1 in any state other than IDLE sets overrun.
  - The new result is discarded; the in-flight product is unaffected.
  - overrun clears only on rst.
- Counter: width $clog2(BEATS), minimum 1 bit. Never wraps past BEATS-1 by construction.
- OUT_W=FP_W degenerates to a single beat with outLast=1 in every PRESENT cycle.
- Elaboration error if FP_W % OUT_W != 0.

Decomposition:
- Package fp_wrapper_pkg holds:
  - FP_W constant.
  - Output-wrapper state enum {IDLE, PRESENT, RELEASE}.
  - Beat-count helper function.
- Sub-module out_wrapper_cu (controller):
  - Inputs: state, counter, fpDone, outAccept.
  - Outputs: load, shift, outReady, outLast, busy.
- out_wrapper instantiates out_wrapper_cu and holds the shift register and overrun flag.

Test Plan:
- Basic transfer (OUT_W=16):
  - fpDone=1 for 1 cycle with fpResult=32'h3FC0_0000; consumer acks 1 cycle after each outReady and drops after 1 cycle.
  - Beat 1: outData=16'h0000, outLast=0. Beat 2: outData=16'h3FC0, outLast=1.
  - busy falls after the second outAccept drop; outReady rises exactly 1 cycle after fpDone.
- Slow consumer:
  - outAccept withheld 10 cycles in PRESENT, then held high 5 cycles in RELEASE.
  - outReady stays 1 for all 10 cycles, then 0 while outAccept=1.
  - outData is stable throughout; the second beat appears only after outAccept=0.
- Overrun:
  - Second fpDone with fpResult=32'hDEAD_BEEF during beat 1 of 32'h1234_5678.
  - overrun=1 from the next cycle; beats are 16'h5678 then 16'h1234; 32'hDEADBEEF is never output.
- Reset mid-operation:
  - rst=1 in RELEASE of beat 1.
  - Next cycle: outReady=0, busy=0, overrun=0.
  - A fresh fpDone with 32'h0000_0001 gives beats 16'h0001 then 16'h0000.
- Parameter sweep:
  - OUT_W=8 with fpResult=32'hA1B2_C3D4 → beats D4, C3, B2, A1; outLast only on A1.
  - OUT_W=32 → single beat 32'hA1B2C3D4 with outLast=1.
- Back-to-back products:
  - fpDone held high continuously.
  - A new capture occurs on the first IDLE cycle after each completed product.
  - overrun=1, since fpDone was present during busy.
